// File: rtl/branch_pc_unit.sv
// Fetch-PC owner and ID-stage control-flow resolver for the 5-stage MIPS pipeline.
// Picks sequential/branch/jump/jr next PC, flushes IF once per redirect, keeps branch stats.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall,
    input  logic             i_br_valid,
    input  logic [2:0]       i_br_type,
    output logic [2:0]       o_cmp_sel,
    input  logic             i_cmp_out,
    input  logic [15:0]      i_br_offset,
    input  logic             i_jump,
    input  logic [25:0]      i_jump_index,
    input  logic             i_jr,
    input  logic [31:0]      i_jr_target,
    output logic [31:0]      o_pc_if,
    output logic [31:0]      o_pc_id,
    output logic             o_flush_if,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_taken_count
);

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StFlush
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           r_state;
    logic [31:0]      r_pc_if;
    logic [31:0]      r_pc_id;
    logic             r_flush_if;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_taken_count;

    state_e           w_state_d;
    logic [31:0]      w_pc_if_d;
    logic [31:0]      w_pc_id_d;
    logic             w_flush_d;
    logic             w_br_inc;
    logic             w_taken_inc;
    logic [CNT_W-1:0] w_br_count_d;
    logic [CNT_W-1:0] w_taken_count_d;

    logic [31:0]      w_pc_if_plus4;
    logic [31:0]      w_pc_id_plus4;
    logic [31:0]      w_br_target;
    logic [31:0]      w_jump_target;
    logic [31:0]      w_target;
    logic             w_type_ok;
    logic             w_br_taken;
    logic             w_redirect;

    assign o_cmp_sel = i_br_type;

    assign w_pc_if_plus4 = r_pc_if + 32'd4;
    assign w_pc_id_plus4 = r_pc_id + 32'd4;
    assign w_br_target   = w_pc_id_plus4 + {{14{i_br_offset[15]}}, i_br_offset, 2'b00};
    assign w_jump_target = {w_pc_id_plus4[31:28], i_jump_index, 2'b00};

    // Encodings above le are undefined comparator selects and must never redirect.
    assign w_type_ok  = (i_br_type <= 3'd4);
    assign w_br_taken = i_br_valid & i_cmp_out & w_type_ok;
    assign w_redirect = ~i_stall & (i_jump | i_jr | w_br_taken);

    always_comb begin
        w_target = w_br_target;
        if (i_jr) begin
            w_target = i_jr_target;
        end else if (i_jump) begin
            w_target = w_jump_target;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_pc_if_d   = r_pc_if;
        w_pc_id_d   = r_pc_id;
        w_flush_d   = r_flush_if;
        w_br_inc    = 1'b0;
        w_taken_inc = 1'b0;
        case (r_state)
            StRun: begin
                if (i_stall) begin
                    w_state_d = StStall;
                end else begin
                    w_br_inc  = i_br_valid;
                    w_pc_id_d = r_pc_if;
                    if (w_redirect) begin
                        w_taken_inc = 1'b1;
                        w_pc_if_d   = w_target;
                        w_flush_d   = 1'b1;
                        w_state_d   = StFlush;
                    end else begin
                        w_pc_if_d = w_pc_if_plus4;
                    end
                end
            end
            // Leaving STALL spends one cycle in RUN-entry so forwarded operands settle.
            StStall: begin
                if (!i_stall) begin
                    w_state_d = StRun;
                end
            end
            StFlush: begin
                if (!i_stall) begin
                    w_pc_if_d = w_pc_if_plus4;
                    w_pc_id_d = r_pc_if;
                    w_flush_d = 1'b0;
                    w_state_d = StRun;
                end
            end
            default: begin
                w_state_d = StRun;
            end
        endcase
    end

    always_comb begin
        w_br_count_d    = r_br_count;
        w_taken_count_d = r_taken_count;
        if (w_br_inc && (r_br_count != CntMax)) begin
            w_br_count_d = r_br_count + CntOne;
        end
        if (w_taken_inc && (r_taken_count != CntMax)) begin
            w_taken_count_d = r_taken_count + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StRun;
            r_pc_if       <= RESET_PC;
            r_pc_id       <= RESET_PC;
            r_flush_if    <= 1'b0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pc_if       <= w_pc_if_d;
            r_pc_id       <= w_pc_id_d;
            r_flush_if    <= w_flush_d;
            r_br_count    <= w_br_count_d;
            r_taken_count <= w_taken_count_d;
        end
    end

    assign o_pc_if       = r_pc_if;
    assign o_pc_id       = r_pc_id;
    assign o_flush_if    = r_flush_if;
    assign o_br_count    = r_br_count;
    assign o_taken_count = r_taken_count;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: directed steps push expected post-edge state,
// a monitor pops and compares after each rising edge. A 2-bit-counter twin checks saturation.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_type = 3'd0;
    logic        cmp_out = 1'b0;
    logic [15:0] br_offset = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;

    logic [2:0]  cmp_sel;
    logic [31:0] pc_if, pc_id, br_count, taken_count;
    logic        flush_if;

    logic [2:0]  s_cmp_sel;
    logic [31:0] s_pc_if, s_pc_id;
    logic        s_flush_if;
    logic [1:0]  s_br_count, s_taken_count;

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    typedef struct {
        int          step;
        logic [31:0] pc_if;
        logic [31:0] pc_id;
        logic        flush;
        logic [31:0] br;
        logic [31:0] taken;
        logic [2:0]  sel;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_br_valid(br_valid),
        .i_br_type(br_type), .o_cmp_sel(cmp_sel), .i_cmp_out(cmp_out),
        .i_br_offset(br_offset), .i_jump(jump), .i_jump_index(jump_index), .i_jr(jr),
        .i_jr_target(jr_target), .o_pc_if(pc_if), .o_pc_id(pc_id), .o_flush_if(flush_if),
        .o_br_count(br_count), .o_taken_count(taken_count)
    );

    branch_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_br_valid(br_valid),
        .i_br_type(br_type), .o_cmp_sel(s_cmp_sel), .i_cmp_out(cmp_out),
        .i_br_offset(br_offset), .i_jump(jump), .i_jump_index(jump_index), .i_jr(jr),
        .i_jr_target(jr_target), .o_pc_if(s_pc_if), .o_pc_id(s_pc_id),
        .o_flush_if(s_flush_if), .o_br_count(s_br_count), .o_taken_count(s_taken_count)
    );

    task automatic chk(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s step=%0d got=%h exp=%h", name, step, got, expv);
        end
    endtask

    function automatic logic [31:0] sat3(input logic [31:0] v);
        return (v > 32'd3) ? 32'd3 : v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_if", e.step, pc_if, e.pc_if);
            chk("pc_id", e.step, pc_id, e.pc_id);
            chk("flush_if", e.step, {31'd0, flush_if}, {31'd0, e.flush});
            chk("br_count", e.step, br_count, e.br);
            chk("taken_count", e.step, taken_count, e.taken);
            chk("cmp_sel", e.step, {29'd0, cmp_sel}, {29'd0, e.sel});
            chk("sat_pc_if", e.step, s_pc_if, e.pc_if);
            chk("sat_flush_if", e.step, {31'd0, s_flush_if}, {31'd0, e.flush});
            chk("sat_br_count", e.step, {30'd0, s_br_count}, sat3(e.br));
            chk("sat_taken_count", e.step, {30'd0, s_taken_count}, sat3(e.taken));
        end
    end

    // Drives this cycle's inputs and queues the state expected after the next rising edge.
    task automatic apply(input logic st, input logic bv, input logic [2:0] bt, input logic co,
                         input logic [15:0] off, input logic jp, input logic [25:0] idx,
                         input logic j_r, input logic [31:0] jrt, input logic [31:0] e_if,
                         input logic [31:0] e_id, input logic e_fl, input logic [31:0] e_br,
                         input logic [31:0] e_tk);
        exp_t e;
        stall = st; br_valid = bv; br_type = bt; cmp_out = co; br_offset = off;
        jump = jp; jump_index = idx; jr = j_r; jr_target = jrt;
        step_no++;
        e.step = step_no; e.pc_if = e_if; e.pc_id = e_id; e.flush = e_fl;
        e.br = e_br; e.taken = e_tk; e.sel = bt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic st, input logic bv, input logic [2:0] bt, input logic co,
                        input logic [15:0] off, input logic jp, input logic [25:0] idx,
                        input logic j_r, input logic [31:0] jrt, input logic [31:0] e_if,
                        input logic [31:0] e_id, input logic e_fl, input logic [31:0] e_br,
                        input logic [31:0] e_tk);
        @(negedge clk);
        apply(st, bv, bt, co, off, jp, idx, j_r, jrt, e_if, e_id, e_fl, e_br, e_tk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_pc_if", 0, pc_if, 32'h3000);
        chk("reset_pc_id", 0, pc_id, 32'h3000);
        chk("reset_flush", 0, {31'd0, flush_if}, 32'd0);
        chk("reset_br", 0, br_count, 32'd0);
        chk("reset_taken", 0, taken_count, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        //     st bv bt   co off       jp idx       jr jrt        pc_if     pc_id    fl br tk
        apply(0, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h3004, 32'h3000, 0, 0, 0);
        step (0, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h3008, 32'h3004, 0, 0, 0);
        step (0, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h300C, 32'h3008, 0, 0, 0);
        // beq taken backwards from pc_id=0x3008
        step (0, 1, 3'd0, 1, 16'hFFFE, 0, 26'h0,    0, 32'h0,    32'h3004, 32'h300C, 1, 1, 1);
        // FLUSH ignores control inputs
        step (0, 1, 3'd0, 1, 16'hFFFE, 1, 26'h3FFFFFF, 1, 32'h8000, 32'h3008, 32'h3004, 0, 1, 1);
        step (0, 1, 3'd1, 0, 16'h0040, 0, 26'h0,    0, 32'h0,    32'h300C, 32'h3008, 0, 2, 1);
        // br_type 101 with cmp_out=1 is never taken
        step (0, 1, 3'd5, 1, 16'h0010, 0, 26'h0,    0, 32'h0,    32'h3010, 32'h300C, 0, 3, 1);
        // jr beats jump
        step (0, 0, 3'd0, 0, 16'h0000, 1, 26'h123,  1, 32'h4000, 32'h4000, 32'h3010, 1, 3, 2);
        step (0, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h4004, 32'h4000, 0, 3, 2);
        // j from pc_id=0x4000
        step (0, 0, 3'd0, 0, 16'h0000, 1, 26'h100,  0, 32'h0,    32'h0400, 32'h4004, 1, 3, 3);
        // stall in FLUSH keeps flush_if high
        step (1, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h0400, 32'h4004, 1, 3, 3);
        step (0, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h0404, 32'h0400, 0, 3, 3);
        step (0, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h0408, 32'h0404, 0, 3, 3);
        // bge taken held off by 3 stall cycles, then one release cycle, then resolves
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 3'd3, 1, 16'h0010, 0, 26'h0, 0, 32'h0,    32'h0408, 32'h0404, 0, 3, 3);
        end
        step (0, 1, 3'd3, 1, 16'h0010, 0, 26'h0,    0, 32'h0,    32'h0408, 32'h0404, 0, 3, 3);
        step (0, 1, 3'd3, 1, 16'h0010, 0, 26'h0,    0, 32'h0,    32'h0448, 32'h0408, 1, 4, 4);
        step (1, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h0448, 32'h0408, 1, 4, 4);

        // asynchronous reset while sitting in FLUSH
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_pc_if", step_no, pc_if, 32'h3000);
        chk("async_pc_id", step_no, pc_id, 32'h3000);
        chk("async_flush", step_no, {31'd0, flush_if}, 32'd0);
        chk("async_br", step_no, br_count, 32'd0);
        chk("async_taken", step_no, taken_count, 32'd0);
        chk("async_sat_br", step_no, {30'd0, s_br_count}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 3'd0, 0, 16'h0000, 0, 26'h0,    0, 32'h0,    32'h3004, 32'h3000, 0, 0, 0);

        @(posedge clk);
        #2;
        chk("queue_drained", step_no, exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
